// File: rtl/msg_rotator_pkg.sv
// msg_rotator_pkg: shared state encoding and default geometry for the message ring.
package msg_rotator_pkg;
   typedef enum logic {S_FILL = 1'b0, S_ROTATE = 1'b1} state_t;
   localparam int DEF_N_SLOTS = 8;
   localparam int DEF_SYM_W = 4;
endpackage

// File: rtl/msg_rotator_sym_slot.sv
// sym_slot: one ring slot, a symbol register taking its left or right neighbour when enabled.
module sym_slot
   import msg_rotator_pkg::*;
#(
   parameter int SYM_W = DEF_SYM_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sel,
   input  logic [SYM_W-1:0] left,
   input  logic [SYM_W-1:0] right,
   output logic [SYM_W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else if (en) q <= sel ? right : left;
   end
endmodule

// File: rtl/msg_rotator.sv
// msg_rotator: loadable symbol ring that rotates on demand in either direction.
// Define MSG_ROTATOR_BOUNCE_EN to reverse direction after every full revolution.
module msg_rotator
   import msg_rotator_pkg::*;
#(
   parameter int N_SLOTS = DEF_N_SLOTS,
   parameter int SYM_W   = DEF_SYM_W
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     Load_valid,
   input  logic [SYM_W-1:0]         Load_data,
   output logic                     Load_ready,
   input  logic                     Step,
   input  logic                     Dir,
   input  logic                     Hold,
   input  logic                     Restart,
   output logic                     Rotating,
   output logic                     Wrap,
   output logic [N_SLOTS*SYM_W-1:0] Q
);
   localparam int FW = $clog2(N_SLOTS + 1);
   localparam int RW = $clog2(N_SLOTS);
   state_t state, state_nx;
   logic [FW-1:0] fill_cnt;
   logic [RW-1:0] rot_cnt;
   logic load_acc, step_acc, fill_done, rot_wrap, shift_en, eff_dir, clr;
   assign Load_ready = state == S_FILL;
   assign Rotating = state == S_ROTATE;
   assign clr = Reset || Restart;
`ifdef MSG_ROTATOR_BOUNCE_EN
   logic flip;
   always_ff @(posedge Clock) begin
      if (clr) flip <= 1'b0;
      else if (rot_wrap) flip <= ~flip;
   end
   assign eff_dir = Rotating && (Dir ^ flip);
`else
   assign eff_dir = Rotating && Dir;
`endif
   always_comb begin
      load_acc = Load_ready && Load_valid;
      step_acc = Rotating && Step && !Hold;
      fill_done = load_acc && fill_cnt == FW'(N_SLOTS - 1);
      rot_wrap = step_acc && rot_cnt == RW'(N_SLOTS - 1);
      shift_en = (load_acc || step_acc) && !Restart;
      state_nx = Restart ? S_FILL : fill_done ? S_ROTATE : state;
   end
   always_ff @(posedge Clock) begin
      if (Reset) state <= S_FILL;
      else state <= state_nx;
   end
   always_ff @(posedge Clock) begin
      if (clr) begin
         fill_cnt <= '0;
         rot_cnt <= '0;
         Wrap <= 1'b0;
      end else begin
         if (load_acc) fill_cnt <= fill_cnt + 1'b1;
         if (step_acc) rot_cnt <= rot_wrap ? '0 : rot_cnt + 1'b1;
         Wrap <= rot_wrap;
      end
   end
   // Slot 0 takes fresh data while filling and closes the ring once rotating.
   for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
      sym_slot #(.SYM_W(SYM_W)) u_slot (
         .clk  (Clock),
         .rst  (clr),
         .en   (shift_en),
         .sel  (eff_dir),
         .left ((i == 0 && !Rotating) ? Load_data : Q[((i + N_SLOTS - 1) % N_SLOTS)*SYM_W +: SYM_W]),
         .right(Q[((i + 1) % N_SLOTS)*SYM_W +: SYM_W]),
         .q    (Q[i*SYM_W +: SYM_W])
      );
   end
endmodule

// File: tb/tb_msg_rotator.sv
// tb_msg_rotator: directed and random stimulus against an array-based model of the ring.
module tb_msg_rotator;
   logic Clock = 1'b0;
   logic Reset, Load_valid, Step, Dir, Hold, Restart;
   logic [3:0] Load_data;
   logic Load_ready, Rotating, Wrap;
   logic [31:0] Q;
   int checks = 0, failures = 0;
   logic [3:0] m [8];
   int fill, rcnt;
   bit rot, wexp, flip;

   msg_rotator dut (
      .Clock(Clock), .Reset(Reset), .Load_valid(Load_valid), .Load_data(Load_data),
      .Load_ready(Load_ready), .Step(Step), .Dir(Dir), .Hold(Hold), .Restart(Restart),
      .Rotating(Rotating), .Wrap(Wrap), .Q(Q)
   );

   always #5 Clock = ~Clock;

   function automatic logic [31:0] pack();
      logic [31:0] p;
      for (int k = 0; k < 8; k++) p[k*4 +: 4] = m[k];
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic rs, input logic lv, input logic [3:0] ld,
                        input logic st, input logic dr, input logic hd);
      logic [3:0] o [8];
      Reset = r; Restart = rs; Load_valid = lv; Load_data = ld; Step = st; Dir = dr; Hold = hd;
      o = m;
      if (r || rs) begin
         for (int k = 0; k < 8; k++) m[k] = '0;
         fill = 0; rcnt = 0; rot = 0; wexp = 0; flip = 0;
      end else begin
         wexp = 0;
         if (!rot) begin
            if (lv) begin
               for (int k = 7; k > 0; k--) m[k] = o[k-1];
               m[0] = ld;
               fill++;
               rot = (fill == 8);
            end
         end else if (st && !hd) begin
            bit d;
            d = dr ^ flip;
            for (int k = 0; k < 8; k++) m[k] = d ? o[(k + 1) % 8] : o[(k + 7) % 8];
            rcnt = (rcnt + 1) % 8;
            if (rcnt == 0) begin
               wexp = 1;
`ifdef MSG_ROTATOR_BOUNCE_EN
               flip = ~flip;
`endif
            end
         end
      end
      @(posedge Clock);
      #1;
      chk("q", Q, pack());
      chk("rotating", 32'(Rotating), 32'(rot));
      chk("load_ready", 32'(Load_ready), 32'(!rot));
      chk("wrap", 32'(Wrap), 32'(wexp));
   endtask

   task automatic load_seq();
      for (int v = 1; v <= 8; v++) cycle(0, 0, 1, 4'(v), 0, 0, 0);
   endtask

   initial begin
      Reset = 1; Restart = 0; Load_valid = 0; Load_data = '0; Step = 0; Dir = 0; Hold = 0;
      for (int k = 0; k < 8; k++) m[k] = '0;
      fill = 0; rcnt = 0; rot = 0; wexp = 0; flip = 0;
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 1, 4'h5, 1, 0, 0);
      chk("reset_q", Q, 32'h0);
      load_seq();
      chk("load_q", Q, 32'h12345678);
      chk("load_rot", 32'(Rotating), 32'd1);
      cycle(0, 0, 0, 0, 1, 0, 0);
      chk("step_dir0", Q, 32'h23456781);
      cycle(0, 1, 0, 0, 0, 0, 0);
      load_seq();
      cycle(0, 0, 1, 4'hf, 1, 1, 0);
      chk("step_dir1", Q, 32'h81234567);
      cycle(0, 1, 0, 0, 0, 0, 0);
      load_seq();
      for (int s = 0; s < 8; s++) cycle(0, 0, 0, 0, 1, 0, 0);
      chk("full_turn_q", Q, 32'h12345678);
      chk("full_turn_wrap", 32'(Wrap), 32'd1);
      cycle(0, 0, 0, 0, 1, 0, 1);
      cycle(0, 0, 0, 0, 1, 1, 1);
      chk("hold_q", Q, 32'h12345678);
      cycle(0, 0, 0, 0, 1, 0, 0);
`ifdef MSG_ROTATOR_BOUNCE_EN
      chk("after_wrap", Q, 32'h81234567);
`else
      chk("after_wrap", Q, 32'h23456781);
`endif
      cycle(0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cycle(0, 0, 1, 4'($urandom), 0, 0, 0);
      cycle(0, 1, 1, 4'($urandom), 1, 0, 0);
      chk("restart_q", Q, 32'h0);
      for (int k = 0; k < 7; k++) cycle(0, 0, 1, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("seven_loads_fill", 32'(Rotating), 32'd0);
      cycle(0, 0, 1, 4'($urandom), 0, 0, 0);
      chk("eighth_load_rot", 32'(Rotating), 32'd1);
      repeat (400)
         cycle(0, $urandom_range(0, 40) == 0, 1'($urandom), 4'($urandom),
               $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 4) == 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      load_seq();
      cycle(1, 0, 1, 4'h9, 1, 0, 0);
      chk("reset_rot_q", Q, 32'h0);
      chk("reset_rot_ready", 32'(Load_ready), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/msg_rotator.md
# msg_rotator

Parametrised message ring: accepts a programmable sequence of `N_SLOTS` symbols of `SYM_W` bits over a valid/ready load port, then rotates them around the slot ring on demand in either direction. It generalises the fixed 8×4-bit hello-sequence cycler: depth, width, content, direction and stepping are all runtime or compile-time controllable. It sits between the message source (host or ROM sequencer) and the segment/display driver, which consumes `Q` directly.

## Interface
Parameters:
- `N_SLOTS`, 8, number of symbol slots; must be ≥ 2.
- `SYM_W`, 4, bits per symbol; must be ≥ 1.

Ports:
- `Clock`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Load_valid`  in  1  a symbol is offered on `Load_data`.
- `Load_data`  in  SYM_W  symbol to append.
- `Load_ready`  out  1  block accepts a symbol this cycle.
- `Step`  in  1  advance the ring by one slot (ROTATE only).
- `Dir`  in  1  0: slot i ← slot i-1, slot 0 ← slot N-1; 1: slot i ← slot i+1, slot N-1 ← slot 0.
- `Hold`  in  1  freeze the ring in ROTATE.
- `Restart`  in  1  discard contents and return to FILL.
- `Rotating`  out  1  high in ROTATE.
- `Wrap`  out  1  one-cycle pulse when the ring completes N_SLOTS steps.
- `Q`  out  N_SLOTS*SYM_W  slot k on `Q[k*SYM_W +: SYM_W]`.

## Operation
- States: FILL, ROTATE.
- Reset: state FILL, all slots 0, `fill_cnt`=0, `rot_cnt`=0, `Wrap`=0, `Rotating`=0, `Load_ready`=1.
- FILL: `Load_ready`=1. On `Load_valid`: slot 0 ← `Load_data`, slot i ← slot i-1, `fill_cnt`++. The accept that brings `fill_cnt` to N_SLOTS-1→N_SLOTS moves to ROTATE. `Step`, `Hold` and `Dir` are ignored.
- ROTATE: `Load_ready`=0; `Load_valid` is ignored. On `Step` with `Hold`=0: shift per effective direction, `rot_cnt` ← (`rot_cnt`+1) mod N_SLOTS. A step that takes `rot_cnt` to 0 sets `Wrap` the next cycle.
- `Restart` (either state): next cycle all slots 0, counters 0, `flip`=0, state FILL. Beats `Step` and `Load_valid` in the same cycle.
- Priority: `Reset` > `Restart` > `Hold` > `Step`.
- Counter widths: `$clog2(N_SLOTS+1)` for `fill_cnt`, `$clog2(N_SLOTS)` for `rot_cnt`. Non-power-of-two N_SLOTS wraps explicitly at N_SLOTS-1.

## Timing
- Load: 1 symbol/cycle. `Q` reflects an accepted symbol the cycle after the accepting edge.
- `Rotating` rises the cycle after the final accept. A `Step` in that first ROTATE cycle is honoured.
- Step latency: 1 cycle. Steps can occur back-to-back every cycle.
- `Wrap`: registered, high exactly one cycle, the cycle after the wrapping step. Cleared by `Reset`/`Restart`.
- `Restart` mid-fill or mid-rotation takes effect at the next edge; no partial shift occurs.

## Configuration
- `MSG_ROTATOR_BOUNCE_EN` defined: an internal `flip` bit toggles on every wrap. Effective direction = `Dir` XOR `flip`, so the message ping-pongs. `flip` is cleared by `Reset`/`Restart`.
- Undefined: effective direction = `Dir`. No `flip` register is present.

## Structure
- `msg_rotator_pkg`: state enum (`S_FILL`, `S_ROTATE`) and the default `N_SLOTS`/`SYM_W` constants.
- Sub-module `sym_slot`: SYM_W-bit register with enable, synchronous clear and a 2:1 next-value mux (left/right neighbour). It is instantiated N_SLOTS times in a generate loop. Slot 0's left source is `Load_data` in FILL and slot N-1 in ROTATE.

## Test plan
(N_SLOTS=8, SYM_W=4)
- Reset, load 1..8 back-to-back → `Q`=32'h12345678, `Rotating`=1 the cycle after the 8th accept, `Load_ready`=0.
- From 32'h12345678, one `Step` with `Dir`=0 → 32'h23456781. One `Step` with `Dir`=1 from 32'h12345678 → 32'h81234567.
- 8 consecutive `Step`s with `Dir`=0 → `Q` returns to 32'h12345678 and `Wrap` pulses exactly one cycle. `Hold`=1 with `Step`=1 leaves `Q` unchanged and does not advance `rot_cnt`.
- Load 3 symbols, assert `Restart` together with `Load_valid` → `Q`=0 and `fill_cnt`=0. Then 8 further loads are required before ROTATE. `Step` during FILL has no effect.
- With BOUNCE_EN: 8 steps with `Dir`=0 give a `Wrap`; the next step yields 32'h81234567. Without it, the next step yields 32'h23456781.
- Assert `Reset` during ROTATE together with `Step` → all outputs return to their reset values the next cycle.
